// File: rtl/line_buf_wr_ctrl_pkg.sv
// Shared definitions for the line-buffer write controller and the 3x3 window
// row multiplexer: row-select codes and buffer rotation helpers.
package line_buf_wr_ctrl_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_IDLE = 2'd0;
  localparam sel_t SEL_A    = 2'd1;
  localparam sel_t SEL_B    = 2'd2;
  localparam sel_t SEL_C    = 2'd3;

  // Buffer that receives the line after the one written into b.
  function automatic sel_t next_buf(input sel_t b);
    sel_t r;
    case (b)
      SEL_A:   r = SEL_B;
      SEL_B:   r = SEL_C;
      SEL_C:   r = SEL_A;
      default: r = SEL_A;
    endcase
    return r;
  endfunction

  // Buffer that holds the line written just before the one in b.
  function automatic sel_t prev_buf(input sel_t b);
    sel_t r;
    case (b)
      SEL_A:   r = SEL_C;
      SEL_B:   r = SEL_A;
      SEL_C:   r = SEL_B;
      default: r = SEL_A;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/line_buf_wr_ctrl_rotator.sv
// Tracks which buffer is being written and how many complete lines are held,
// and produces the raw (unaligned) row-select codes for the accepting pixel.
// frame_start takes effect in the same cycle so a coincident pixel already
// sees the restarted state.
module line_buf_rotator
  import line_buf_wr_ctrl_pkg::*;
(
  input  logic clk,
  input  logic aclr,
  input  logic frame_start,
  input  logic advance,
  output sel_t sel_row1,
  output sel_t sel_row2,
  output sel_t sel_row3,
  output logic win
);

  sel_t       wptr;
  logic [1:0] filled;
  sel_t       eff_wptr;
  logic [1:0] eff_filled;
  sel_t       wptr_nxt;
  logic [1:0] filled_nxt;

  // State register: write pointer and saturating completed-line count.
  always_ff @(posedge clk) begin
    if (aclr) begin
      wptr   <= SEL_A;
      filled <= 2'd0;
    end else begin
      wptr   <= wptr_nxt;
      filled <= filled_nxt;
    end
  end

  // Next state: apply a frame restart first, then rotate on line end.
  always_comb begin
    eff_wptr   = wptr;
    eff_filled = filled;
    if (frame_start) begin
      eff_wptr   = SEL_A;
      eff_filled = 2'd0;
    end else begin
      eff_wptr   = wptr;
      eff_filled = filled;
    end
    wptr_nxt   = eff_wptr;
    filled_nxt = eff_filled;
    if (advance) begin
      wptr_nxt   = next_buf(eff_wptr);
      filled_nxt = (eff_filled == 2'd2) ? 2'd2 : (eff_filled + 2'd1);
    end else begin
      wptr_nxt   = eff_wptr;
      filled_nxt = eff_filled;
    end
  end

  // Outputs: newest row is the buffer being written, older rows follow back.
  always_comb begin
    sel_row3 = eff_wptr;
    sel_row2 = SEL_IDLE;
    sel_row1 = SEL_IDLE;
    win      = 1'b0;
    if (eff_filled != 2'd0) begin
      sel_row2 = prev_buf(eff_wptr);
    end else begin
      sel_row2 = SEL_IDLE;
    end
    if (eff_filled == 2'd2) begin
      sel_row1 = prev_buf(prev_buf(eff_wptr));
      win      = 1'b1;
    end else begin
      sel_row1 = SEL_IDLE;
      win      = 1'b0;
    end
  end

endmodule

// File: rtl/line_buf_wr_ctrl.sv
// Write-side controller for three rotating line buffers. Stage 1 drives the
// RAM write port; stage 2 presents row selects, win_valid and row_end aligned
// with the RAM read data one cycle later.
module line_buf_wr_ctrl
  import line_buf_wr_ctrl_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int LINE_LEN = 640,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  input  logic              frame_start,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en_a,
  output logic              wr_en_b,
  output logic              wr_en_c,
  output logic [ADDR_W-1:0] rd_addr,
  output sel_t              sel_row1,
  output sel_t              sel_row2,
  output sel_t              sel_row3,
  output logic              row_end,
  output logic              win_valid
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_LEN - 1);

  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] eff_col;
  logic              last_col;
  logic              advance;
  sel_t              raw_sel1;
  sel_t              raw_sel2;
  sel_t              raw_sel3;
  logic              raw_win;
  logic              en_a;
  logic              en_b;
  logic              en_c;

  sel_t              s1_sel1;
  sel_t              s1_sel2;
  sel_t              s1_sel3;
  logic              s1_win;
  logic              s1_last;
  logic              s1_valid;

  // Column seen by the current pixel, restarting at 0 on frame_start.
  always_comb begin
    eff_col = col;
    if (frame_start) begin
      eff_col = '0;
    end else begin
      eff_col = col;
    end
    last_col = (eff_col == LAST_COL);
    advance  = pix_valid && last_col;
  end

  line_buf_rotator u_rotator (
    .clk         (clk),
    .aclr        (aclr),
    .frame_start (frame_start),
    .advance     (advance),
    .sel_row1    (raw_sel1),
    .sel_row2    (raw_sel2),
    .sel_row3    (raw_sel3),
    .win         (raw_win)
  );

  // Decode the one-hot write enable from the buffer being written.
  always_comb begin
    en_a = 1'b0;
    en_b = 1'b0;
    en_c = 1'b0;
    case (raw_sel3)
      SEL_A:   en_a = pix_valid;
      SEL_B:   en_b = pix_valid;
      SEL_C:   en_c = pix_valid;
      default: begin
        en_a = 1'b0;
        en_b = 1'b0;
        en_c = 1'b0;
      end
    endcase
  end

  // Column counter: advances per accepted pixel, wraps at end of line.
  always_ff @(posedge clk) begin
    if (aclr) begin
      col <= '0;
    end else if (pix_valid) begin
      col <= last_col ? '0 : (eff_col + ADDR_W'(1));
    end else begin
      col <= eff_col;
    end
  end

  // Stage 1: RAM write port plus the metadata travelling with the pixel.
  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_en_a  <= 1'b0;
      wr_en_b  <= 1'b0;
      wr_en_c  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      s1_sel1  <= SEL_IDLE;
      s1_sel2  <= SEL_IDLE;
      s1_sel3  <= SEL_IDLE;
      s1_win   <= 1'b0;
      s1_last  <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      wr_en_a  <= en_a;
      wr_en_b  <= en_b;
      wr_en_c  <= en_c;
      s1_valid <= pix_valid;
      s1_win   <= pix_valid && raw_win;
      s1_last  <= advance;
      if (pix_valid) begin
        wr_addr <= eff_col;
        wr_data <= pix_data;
        s1_sel1 <= raw_sel1;
        s1_sel2 <= raw_sel2;
        s1_sel3 <= raw_sel3;
      end else begin
        wr_addr <= wr_addr;
        wr_data <= wr_data;
        s1_sel1 <= s1_sel1;
        s1_sel2 <= s1_sel2;
        s1_sel3 <= s1_sel3;
      end
    end
  end

  // Stage 2: selects and flags aligned with the RAM read data.
  always_ff @(posedge clk) begin
    if (aclr) begin
      sel_row1  <= SEL_IDLE;
      sel_row2  <= SEL_IDLE;
      sel_row3  <= SEL_IDLE;
      win_valid <= 1'b0;
      row_end   <= 1'b0;
    end else if (s1_valid) begin
      sel_row1  <= s1_sel1;
      sel_row2  <= s1_sel2;
      sel_row3  <= s1_sel3;
      win_valid <= s1_win;
      row_end   <= s1_last;
    end else begin
      win_valid <= 1'b0;
      row_end   <= 1'b0;
    end
  end

  // The read side always addresses the location currently being written.
  assign rd_addr = wr_addr;

endmodule

// File: tb/tb_line_buf_wr_ctrl.sv
// Scoreboard bench for line_buf_wr_ctrl with LINE_LEN=4: directed lines
// followed by randomized pixels, frame restarts and resets.
module tb_line_buf_wr_ctrl;

  localparam int DW = 10;
  localparam int LL = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          aclr = 1'b1;
  logic [DW-1:0] pix_data = '0;
  logic          pix_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en_a, wr_en_b, wr_en_c;
  logic [AW-1:0] rd_addr;
  logic [1:0]    sel_row1, sel_row2, sel_row3;
  logic          row_end, win_valid;

  always #5 clk = ~clk;

  line_buf_wr_ctrl #(.DATA_W(DW), .LINE_LEN(LL), .ADDR_W(AW)) dut (
    .clk(clk), .aclr(aclr), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start), .wr_data(wr_data), .wr_addr(wr_addr),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_en_c(wr_en_c),
    .rd_addr(rd_addr), .sel_row1(sel_row1), .sel_row2(sel_row2),
    .sel_row3(sel_row3), .row_end(row_end), .win_valid(win_valid)
  );

  typedef struct { int bufn; int addr; int data; } wexp_t;
  typedef struct { int s1; int s2; int s3; int win; int last; } oexp_t;

  wexp_t wq[$];
  oexp_t oq[$];
  int total = 0;
  int bad   = 0;

  // Reference model: column, buffer number (1=A,2=B,3=C), completed lines.
  int m_col, m_buf, m_filled;

  function automatic int nextb(input int b); return (b % 3) + 1; endfunction
  function automatic int prevb(input int b); return ((b + 1) % 3) + 1; endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_buf = 1; m_filled = 0;
  endtask

  task automatic model_accept(input int d);
    oexp_t o;
    o.s3   = m_buf;
    o.s2   = (m_filled >= 1) ? prevb(m_buf) : 0;
    o.s1   = (m_filled == 2) ? prevb(prevb(m_buf)) : 0;
    o.win  = (m_filled == 2) ? 1 : 0;
    o.last = (m_col == LL - 1) ? 1 : 0;
    wq.push_back('{m_buf, m_col, d});
    oq.push_back(o);
    if (m_col == LL - 1) begin
      m_col = 0;
      m_buf = nextb(m_buf);
      if (m_filled < 2) m_filled++;
    end else begin
      m_col++;
    end
  endtask

  // One input cycle: drive, predict, then let the clock edge sample it.
  task automatic cyc(input bit v, input int d, input bit fs);
    pix_valid   = v;
    pix_data    = DW'(d);
    frame_start = fs;
    if (fs) model_reset();
    if (v) model_accept(d);
    @(posedge clk); #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic apply_aclr(input int n);
    aclr      = 1'b1;
    pix_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    wq.delete();
    oq.delete();
    model_reset();
    aclr = 1'b0;
  endtask

  // Monitor bookkeeping: reset seen at the last edge, write seen last cycle,
  // and the select values the outputs should be holding.
  logic aclr_q = 1'b1;
  bit   prev_wr = 1'b0;
  int   h1 = 0, h2 = 0, h3 = 0;

  always @(posedge clk) aclr_q <= aclr;

  always @(negedge clk) begin
    int n;
    wexp_t e;
    oexp_t o;
    n = int'(wr_en_a) + int'(wr_en_b) + int'(wr_en_c);
    if (aclr_q) begin
      chk("rst_wr_en", n, 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_wr_data", int'(wr_data), 0);
      chk("rst_sel_row1", int'(sel_row1), 0);
      chk("rst_sel_row2", int'(sel_row2), 0);
      chk("rst_sel_row3", int'(sel_row3), 0);
      chk("rst_win_valid", int'(win_valid), 0);
      chk("rst_row_end", int'(row_end), 0);
      h1 = 0; h2 = 0; h3 = 0;
      prev_wr = 1'b0;
    end else begin
      if (n != 0) begin
        chk("wr_onehot", n, 1);
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = wq.pop_front();
          chk("wr_buf", wr_en_a ? 1 : (wr_en_b ? 2 : 3), e.bufn);
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("rd_addr", int'(rd_addr), e.addr);
          chk("wr_data", int'(wr_data), e.data);
        end
      end
      if (prev_wr) begin
        if (oq.size() == 0) begin
          chk("missing_out", 1, 0);
        end else begin
          o = oq.pop_front();
          chk("sel_row1", int'(sel_row1), o.s1);
          chk("sel_row2", int'(sel_row2), o.s2);
          chk("sel_row3", int'(sel_row3), o.s3);
          chk("win_valid", int'(win_valid), o.win);
          chk("row_end", int'(row_end), o.last);
          h1 = o.s1; h2 = o.s2; h3 = o.s3;
        end
      end else begin
        chk("idle_row_end", int'(row_end), 0);
        chk("idle_win_valid", int'(win_valid), 0);
        chk("hold_sel_row1", int'(sel_row1), h1);
        chk("hold_sel_row2", int'(sel_row2), h2);
        chk("hold_sel_row3", int'(sel_row3), h3);
      end
      prev_wr = (n != 0);
    end
  end

  initial begin
    int r;
    model_reset();
    // Reset held two cycles, then idle.
    apply_aclr(2);
    repeat (4) cyc(1'b0, 0, 1'b0);
    // Lines 1..3 back-to-back onto A, B, C.
    for (int l = 1; l <= 3; l++)
      for (int c = 0; c < LL; c++) cyc(1'b1, l * 10 + c, 1'b0);
    // Line 4 back on A with gaps mid-line.
    cyc(1'b1, 40, 1'b0); cyc(1'b0, 0, 1'b0);
    cyc(1'b1, 41, 1'b0); cyc(1'b0, 0, 1'b0); cyc(1'b0, 0, 1'b0);
    cyc(1'b1, 42, 1'b0); cyc(1'b1, 43, 1'b0);
    // Line 5 aborted at column 2 by a frame restart with a pixel.
    cyc(1'b1, 50, 1'b0); cyc(1'b1, 51, 1'b0); cyc(1'b1, 52, 1'b1);
    for (int c = 1; c < LL + 2; c++) cyc(1'b1, 60 + c, 1'b0);
    // Reset in the middle of line 3, then restart.
    cyc(1'b1, 70, 1'b1);
    for (int c = 1; c < 2 * LL + 2; c++) cyc(1'b1, 70 + c, 1'b0);
    apply_aclr(1);
    for (int c = 0; c < LL + 1; c++) cyc(1'b1, 90 + c, 1'b0);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) apply_aclr(1 + int'($urandom_range(0, 1)));
      else cyc(r < 75, int'($urandom_range(0, 1023)), $urandom_range(0, 29) == 0);
    end
    repeat (4) cyc(1'b0, 0, 1'b0);
    chk("wq_drained", wq.size(), 0);
    chk("oq_drained", oq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
